// File: rtl/sccpu_pkg.sv
// Shared SCCPU load/store definitions: access sizes, LSU FSM states,
// byte-enable patterns and the alignment rule.
package sccpu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Operation fields held for the life of one bus transaction.
    typedef struct packed {
        logic       load;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] addr_lo;
        logic [4:0] rd;
    } lsu_op_t;

    // Reserved size code behaves as a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            default: misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication / byte enables and
// load field extraction with sign or zero extension.
module lsu_align
    import sccpu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [1:0]  lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Endianness only moves the byte lane; halves always follow addr[1].
    assign lane = BIG_ENDIAN ? (2'd3 - addr_lo_i) : addr_lo_i;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = BE_BYTE0 << lane;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sign_i & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one req/gnt/rvalid data-memory transaction per memory
// instruction, stalling the core while in flight and writing back loads.
module load_store_unit
    import sccpu_pkg::*;
#(
    parameter logic [7:0] TIMEOUT    = 8'd255,
    parameter bit         BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_load,
    input  logic [1:0]  op_size,
    input  logic        op_signed,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [4:0]  op_rd,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_misalign,
    output logic        exc_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    lsu_op_t     op_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic [3:0]  mem_be_q;
    logic        exc_mis_q, exc_mis_d, exc_to_q, exc_to_d;
    logic        accept, capture, aligned_op, timeout_hit, in_idle;

    logic [1:0]  al_size, al_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;

    // Store lanes come from the live op in IDLE; load extraction uses the latched op.
    assign in_idle = (state_q == ST_IDLE);
    assign al_size = in_idle ? op_size       : op_q.size;
    assign al_addr = in_idle ? op_addr[1:0]  : op_q.addr_lo;

    lsu_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .size_i    (al_size),
        .addr_lo_i (al_addr),
        .sign_i    (op_q.sgn),
        .wdata_i   (op_wdata),
        .rdata_i   (mem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    assign aligned_op  = op_valid && !misaligned(op_size, op_addr[1:0]);
    // Fires on the TIMEOUT-th cycle spent in REQ+WAIT; bus responses that cycle are dropped.
    assign timeout_hit = (state_q == ST_REQ || state_q == ST_WAIT) && (cnt_q == TIMEOUT - 8'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        capture   = 1'b0;
        exc_mis_d = 1'b0;
        exc_to_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                exc_mis_d = op_valid && misaligned(op_size, op_addr[1:0]);
                if (aligned_op) begin
                    accept  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (timeout_hit) begin
                    exc_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (mem_gnt) begin
                    if (!op_q.load) begin
                        state_d = ST_DONE;
                    end else if (mem_rvalid) begin
                        capture = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (timeout_hit) begin
                    exc_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            cnt_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            wb_data_q   <= 32'd0;
            exc_mis_q   <= 1'b0;
            exc_to_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exc_mis_q <= exc_mis_d;
            exc_to_q  <= exc_to_d;
            if (accept) begin
                op_q        <= '{load: op_load, size: op_size, sgn: op_signed,
                                 addr_lo: op_addr[1:0], rd: op_rd};
                mem_we_q    <= !op_load;
                mem_addr_q  <= {op_addr[31:2], 2'b00};
                mem_be_q    <= al_be;
                mem_wdata_q <= al_wdata;
            end
            if (capture) wb_data_q <= al_rdata;
        end
    end

    assign stall        = (in_idle && aligned_op) || state_q == ST_REQ || state_q == ST_WAIT;
    assign mem_req      = (state_q == ST_REQ);
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_en        = (state_q == ST_DONE) && op_q.load && (op_q.rd != 5'd0);
    assign wb_rd        = op_q.rd;
    assign wb_data      = wb_data_q;
    assign exc_misalign = exc_mis_q;
    assign exc_timeout  = exc_to_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver pushes expected bus
// requests and responses from a plain-arithmetic model, a monitor checks them.
module tb_load_store_unit;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_load, op_signed;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic [4:0]  op_rd;
    logic        stall, wb_en, exc_misalign, exc_timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(8'(TMO)), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_load(op_load), .op_size(op_size), .op_signed(op_signed),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
        .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_timeout(exc_timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    // kind: 0 = write-back, 1 = misalign exception, 2 = timeout exception
    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] data;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int lane = int'(a[1:0]);
        if (sz == 2'd0) return 4'(1 << lane);
        if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sg,
                                           input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (r >> (8 * int'(a[1:0]))) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (r >> (16 * int'(a[1]))) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    // ---------------- driver helpers ----------------
    // Inputs change 1 time unit after the rising edge; stall is sampled 2 later.
    task automatic tick(inout int sc);
        #2;
        sc += int'(stall);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit ld, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input int gd, input int rdly, input logic [31:0] rdat, input bit no_gnt);
        int sc = 0;
        int exp_st;
        bit mis = m_mis(sz, a);
        if (mis) begin
            rsp_q.push_back('{1, 5'd0, 32'd0});
            exp_st = 0;
        end else begin
            bus_q.push_back('{!ld, a & ~32'h3, m_be(sz, a), m_wdata(sz, wd)});
            if (no_gnt) begin
                rsp_q.push_back('{2, 5'd0, 32'd0});
                exp_st = 1 + TMO;
            end else begin
                if (ld && rd != 5'd0) rsp_q.push_back('{0, rd, m_load(sz, sg, a, rdat)});
                exp_st = 2 + gd + (ld ? rdly : 0);
            end
        end
        op_valid = 1'b1; op_load = ld; op_size = sz; op_signed = sg;
        op_addr = a; op_wdata = wd; op_rd = rd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick(sc);
        op_valid = 1'b0;
        if (mis) begin
            tick(sc); tick(sc);
        end else if (no_gnt) begin
            // A grant on the timeout cycle itself must be ignored.
            for (int i = 0; i < TMO + 2; i++) begin
                mem_gnt = (i == TMO - 1);
                tick(sc);
            end
            mem_gnt = 1'b0;
        end else begin
            repeat (gd) tick(sc);
            mem_gnt = 1'b1;
            if (ld && rdly == 0) begin mem_rvalid = 1'b1; mem_rdata = rdat; end
            tick(sc);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (ld && rdly > 0) begin
                repeat (rdly - 1) tick(sc);
                mem_rvalid = 1'b1; mem_rdata = rdat;
                tick(sc);
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
            tick(sc); tick(sc);
        end
        chk("stall_cycles", sc, exp_st);
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit   prev_req = 1'b0;
        rsp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (mem_req) begin
                    if (bus_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL bus_unexpected: mem_req=1 addr=%h, required no request", mem_addr);
                    end else begin
                        chk("bus_we",   mem_we,   bus_q[0].we);
                        chk("bus_addr", mem_addr, bus_q[0].addr);
                        chk("bus_be",   mem_be,   bus_q[0].be);
                        if (bus_q[0].we) chk("bus_wdata", mem_wdata, bus_q[0].wdata);
                    end
                end else if (prev_req && bus_q.size() > 0) begin
                    void'(bus_q.pop_front());
                end
                prev_req = mem_req;
                if (wb_en || exc_misalign || exc_timeout) begin
                    if (rsp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rsp_unexpected: wb_en=%b mis=%b to=%b, required none",
                                 wb_en, exc_misalign, exc_timeout);
                    end else begin
                        e = rsp_q.pop_front();
                        k = wb_en ? 0 : (exc_misalign ? 1 : 2);
                        chk("rsp_kind", k, e.kind);
                        chk("rsp_onehot", int'(wb_en) + int'(exc_misalign) + int'(exc_timeout), 1);
                        if (e.kind == 0) begin
                            chk("wb_rd",   wb_rd,   e.rd);
                            chk("wb_data", wb_data, e.data);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int dummy = 0;
        bit ld, sg, ng;
        logic [1:0] sz;
        logic [31:0] a;

        rst = 1'b1;
        op_valid = 1'b0; op_load = 1'b0; op_size = 2'd0; op_signed = 1'b0;
        op_addr = 32'd0; op_wdata = 32'd0; op_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_stall",   stall,   1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_wb_en",   wb_en,   1'b0);
        chk("rst_exc",     {exc_misalign, exc_timeout}, 2'b00);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be",   mem_be,   4'd0);
        chk("rst_wb_data",  wb_data,  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(dummy);

        // sb, lb/lbu, lh with delayed gnt and rvalid
        run_op(0, 2'd0, 0, 32'h1003, 32'h0000_00A5, 5'd0, 0, 0, 32'd0, 0);
        run_op(1, 2'd0, 1, 32'h2001, 32'd0, 5'd5, 0, 0, 32'h1234_8056, 0);
        run_op(1, 2'd0, 0, 32'h2001, 32'd0, 5'd5, 0, 0, 32'h1234_8056, 0);
        run_op(1, 2'd1, 1, 32'h2002, 32'd0, 5'd9, 2, 3, 32'h8001_FFFF, 0);
        // misaligned lw and sh
        run_op(1, 2'd2, 0, 32'h3002, 32'd0, 5'd7, 0, 0, 32'd0, 0);
        run_op(0, 2'd1, 0, 32'h3001, 32'h1234_5678, 5'd0, 0, 0, 32'd0, 0);
        // lw timeout then a normal sw
        run_op(1, 2'd2, 0, 32'h4000, 32'd0, 5'd3, 0, 0, 32'd0, 1);
        run_op(0, 2'd2, 0, 32'h4004, 32'hDEAD_BEEF, 5'd0, 1, 0, 32'd0, 0);
        // load with rd=0 must not write back
        run_op(1, 2'd2, 0, 32'h5000, 32'd0, 5'd0, 0, 1, 32'hCAFE_F00D, 0);

        // reset while waiting for rvalid
        bus_q.push_back('{1'b0, 32'h6000, 4'hF, 32'd0});
        op_valid = 1'b1; op_load = 1'b1; op_size = 2'd2; op_addr = 32'h6000; op_rd = 5'd4;
        tick(dummy);
        op_valid = 1'b0; mem_gnt = 1'b1;
        tick(dummy);
        mem_gnt = 1'b0;
        tick(dummy);
        rst = 1'b1;
        #1;
        chk("rstw_mem_req", mem_req, 1'b0);
        chk("rstw_stall",   stall,   1'b0);
        chk("rstw_wb_en",   wb_en,   1'b0);
        tick(dummy);
        rst = 1'b0;
        tick(dummy);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick(dummy);
        mem_rvalid = 1'b0;
        tick(dummy); tick(dummy);

        // randomized mix
        for (int n = 0; n < 60; n++) begin
            ld = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd0) ? a[1:0] : (sz == 2'd1 ? {a[1], 1'b0} : 2'b00);
            ng = ($urandom_range(0, 15) == 0);
            run_op(ld, sz, sg, a, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, ng);
        end

        repeat (4) tick(dummy);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
